ex_mem_latch: RTL and testbench
===============================

// Module: ex_mem_latch
// PURPOSE
// - EX/MEM pipeline register with data-memory request sequencing; sits between execute and the MEM/WB latch.
// - Captures execute results and controls; drives dREN/dWEN/daddr/dstore to the cache.
// - Holds each request until dhit; raises dstall to the hazard unit while an access is pending.
// - Injects bubbles on flush; makes halt sticky.
// PARAMETERS
// - WORD_W  32  data/address width
// - REG_W   5   register-index width
// - OP_W    6   opcode width
// PORTS
// - CLK        in   1       clock, rising edge
// - nRST       in   1       reset, asynchronous, active-low
// - ihit       in   1       instruction fetch hit; pipeline advance enable
// - dhit       in   1       data cache hit/complete for the current request
// - dmemload   in   WORD_W  load data from cache, valid with dhit
// - flush      in   1       hazard-unit flush: next capture is a bubble
// - alu_out    in   WORD_W  execute result / memory address
// - st_data    in   WORD_W  store data
// - npc, ext   in   WORD_W  next PC, extended immediate
// - wreg       in   REG_W   destination register
// - opcode     in   OP_W    opcode
// - MemRead, MemWrite, MemToReg, Reg_Wen, jal, halt  in  1 each  controls from execute
// - *_q        out  -       registered copy of each data/control input above
// - dREN, dWEN out  1       cache read/write request
// - daddr      out  WORD_W  = alu_out_q
// - dstore     out  WORD_W  = st_data_q
// - load_data  out  WORD_W  load result to MEM/WB
// - dstall     out  1       memory stage busy
// BEHAVIOUR
// - Reset: all *_q, load_data, dREN, dWEN and dstall are 0; FSM in IDLE; halt_q is 0.
// - Advance condition: adv = ihit & ~dstall.
//   - On adv, every *_q is loaded from its input.
//   - If flush=1, or halt_q=1 already, load a bubble instead: all controls 0, data fields 0.
//   - No adv: all *_q hold.
// - halt_q is sticky: once 1, it stays 1 until reset.
// - FSM states: IDLE, ACCESS, DONE.
//   - IDLE/DONE with adv, and the captured op has MemRead|MemWrite: go to ACCESS. Otherwise go to IDLE.
//   - ACCESS & dhit: if adv (ihit) in the same cycle, apply the IDLE/DONE capture rule above. Else go to DONE.
//   - DONE: hold until adv.
// - Requests: dREN = (state==ACCESS) & MemRead_q, and dWEN = (state==ACCESS) & MemWrite_q.
//   - Both are 0 in IDLE and DONE, so a request is never re-issued after its dhit.
// - dstall = (state==ACCESS) & ~dhit. This is combinational, so a hit advances in the same cycle.
// - Load data:
//   - load_q captures dmemload on dhit in ACCESS.
//   - load_data = (state==DONE) ? load_q : dmemload.
// - Simultaneous flush with dstall=1: flush is ignored. The pending access completes first; the flush is reapplied by the hazard unit.
// - Reset mid-access: requests drop immediately (async); no partial state survives.
// - Back-to-back loads: ACCESS goes directly to ACCESS on dhit&ihit, with a new address that same cycle's next edge.
// CONFIGURATION
// - EXMEM_PERF_EN defined: adds outputs perf_stall (WORD_W) and perf_memops (WORD_W).
//   - perf_stall: counts cycles with dstall=1.
//   - perf_memops: counts ACCESS entries.
//   - Both saturate at all-ones and reset to 0.
// - EXMEM_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Reset with ihit=1: after nRST rises, all outputs are 0, dREN=dWEN=0, dstall=0.
// - lw, addr 0x100, dhit after 3 cycles:
//   - dREN=1 and dstall=1 for 3 cycles, *_q held.
//   - On dhit with dmemload=0xDEADBEEF: load_data=0xDEADBEEF, adv occurs, dREN=0 next cycle.
// - sw, addr 0x200, st_data=0x1234, dhit while ihit=0:
//   - dWEN drops after dhit; state DONE; dstall=0.
//   - Advances on the next ihit; no second write is issued.
// - flush=1 with adv on an add (Reg_Wen=1): next-cycle Reg_Wen_q=0, wreg_q=0, no memory request.
// - halt captured, then a lw presented: halt_q stays 1, later captures are bubbles, dREN never asserts.
// - EXMEM_PERF_EN: two lws each stalling 2 cycles -> perf_stall=4, perf_memops=2.

Source files
------------

// File: rtl/ex_mem_latch.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_latch
// Description : EX/MEM pipeline register with data-memory request
//               sequencing. Captures execute results/controls, issues one
//               cache request per memory op and holds it until dhit, and
//               stalls the pipeline (dstall) while that request is pending.
//               Flush and an already-captured halt inject bubbles; halt is
//               sticky until reset.
// Ports       : CLK, nRST (async active-low)
//               ihit, dhit, dmemload, flush        - pipeline/cache status
//               alu_out, st_data, npc, ext, wreg, opcode,
//               MemRead, MemWrite, MemToReg, Reg_Wen, jal, halt
//                                                  - execute-stage inputs
//               *_q                                - registered copies
//               dREN, dWEN, daddr, dstore          - cache request
//               load_data                          - load result to MEM/WB
//               dstall                             - memory stage busy
//               perf_stall, perf_memops            - only with EXMEM_PERF_EN
// Option      : EXMEM_PERF_EN adds saturating stall/memory-op counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_latch #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              flush,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [WORD_W-1:0] st_data,
  input  logic [WORD_W-1:0] npc,
  input  logic [WORD_W-1:0] ext,
  input  logic [REG_W-1:0]  wreg,
  input  logic [OP_W-1:0]   opcode,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              Reg_Wen,
  input  logic              jal,
  input  logic              halt,
  output logic [WORD_W-1:0] alu_out_q,
  output logic [WORD_W-1:0] st_data_q,
  output logic [WORD_W-1:0] npc_q,
  output logic [WORD_W-1:0] ext_q,
  output logic [REG_W-1:0]  wreg_q,
  output logic [OP_W-1:0]   opcode_q,
  output logic              MemRead_q,
  output logic              MemWrite_q,
  output logic              MemToReg_q,
  output logic              Reg_Wen_q,
  output logic              jal_q,
  output logic              halt_q,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] load_data,
`ifdef EXMEM_PERF_EN
  output logic [WORD_W-1:0] perf_stall,
  output logic [WORD_W-1:0] perf_memops,
`endif
  output logic              dstall
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [WORD_W-1:0] load_q;
  logic              adv;
  logic              bubble;
  logic              mem_op;

  // dstall is combinational on dhit so a hit lets the pipeline advance in
  // the same cycle the data returns.
  assign dstall = (state == ACCESS) & ~dhit;
  assign adv    = ihit & ~dstall;
  assign bubble = flush | halt_q;
  // Memory op as it will be captured (bubbles never start an access).
  assign mem_op = ~bubble & (MemRead | MemWrite);

  assign dREN      = (state == ACCESS) & MemRead_q;
  assign dWEN      = (state == ACCESS) & MemWrite_q;
  assign daddr     = alu_out_q;
  assign dstore    = st_data_q;
  assign load_data = (state == DONE) ? load_q : dmemload;

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (adv) next_state = mem_op ? ACCESS : IDLE;
      end
      ACCESS: begin
        // adv here implies dhit; back-to-back memory ops stay in ACCESS.
        if (adv)       next_state = mem_op ? ACCESS : IDLE;
        else if (dhit) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      load_q <= '0;
    end else begin
      state <= next_state;
      if (state == ACCESS && dhit) load_q <= dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      alu_out_q  <= '0;
      st_data_q  <= '0;
      npc_q      <= '0;
      ext_q      <= '0;
      wreg_q     <= '0;
      opcode_q   <= '0;
      MemRead_q  <= 1'b0;
      MemWrite_q <= 1'b0;
      MemToReg_q <= 1'b0;
      Reg_Wen_q  <= 1'b0;
      jal_q      <= 1'b0;
      halt_q     <= 1'b0;
    end else if (adv) begin
      if (bubble) begin
        alu_out_q  <= '0;
        st_data_q  <= '0;
        npc_q      <= '0;
        ext_q      <= '0;
        wreg_q     <= '0;
        opcode_q   <= '0;
        MemRead_q  <= 1'b0;
        MemWrite_q <= 1'b0;
        MemToReg_q <= 1'b0;
        Reg_Wen_q  <= 1'b0;
        jal_q      <= 1'b0;
        // Sticky: a captured halt survives every later bubble.
        halt_q     <= halt_q;
      end else begin
        alu_out_q  <= alu_out;
        st_data_q  <= st_data;
        npc_q      <= npc;
        ext_q      <= ext;
        wreg_q     <= wreg;
        opcode_q   <= opcode;
        MemRead_q  <= MemRead;
        MemWrite_q <= MemWrite;
        MemToReg_q <= MemToReg;
        Reg_Wen_q  <= Reg_Wen;
        jal_q      <= jal;
        halt_q     <= halt;
      end
    end
  end

`ifdef EXMEM_PERF_EN
  localparam logic [WORD_W-1:0] WORD_ONE = {{(WORD_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_stall  <= '0;
      perf_memops <= '0;
    end else begin
      if (dstall && !(&perf_stall))
        perf_stall <= perf_stall + WORD_ONE;
      // Every transition into ACCESS, including ACCESS->ACCESS.
      if (adv && mem_op && !(&perf_memops))
        perf_memops <= perf_memops + WORD_ONE;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_latch
// Description : Directed self-checking bench for ex_mem_latch. Inputs change
//               1 time unit after the rising edge; outputs are checked 1 time
//               unit after inputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_latch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, flush;
  logic [31:0] dmemload, alu_out, st_data, npc, ext;
  logic [4:0]  wreg;
  logic [5:0]  opcode;
  logic        MemRead, MemWrite, MemToReg, Reg_Wen, jal, halt;
  logic [31:0] alu_out_q, st_data_q, npc_q, ext_q;
  logic [4:0]  wreg_q;
  logic [5:0]  opcode_q;
  logic        MemRead_q, MemWrite_q, MemToReg_q, Reg_Wen_q, jal_q, halt_q;
  logic        dREN, dWEN, dstall;
  logic [31:0] daddr, dstore, load_data;
`ifdef EXMEM_PERF_EN
  logic [31:0] perf_stall, perf_memops;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ex_mem_latch dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
    .flush(flush), .alu_out(alu_out), .st_data(st_data), .npc(npc), .ext(ext),
    .wreg(wreg), .opcode(opcode), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .Reg_Wen(Reg_Wen), .jal(jal), .halt(halt),
    .alu_out_q(alu_out_q), .st_data_q(st_data_q), .npc_q(npc_q), .ext_q(ext_q),
    .wreg_q(wreg_q), .opcode_q(opcode_q), .MemRead_q(MemRead_q),
    .MemWrite_q(MemWrite_q), .MemToReg_q(MemToReg_q), .Reg_Wen_q(Reg_Wen_q),
    .jal_q(jal_q), .halt_q(halt_q), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .load_data(load_data),
`ifdef EXMEM_PERF_EN
    .perf_stall(perf_stall), .perf_memops(perf_memops),
`endif
    .dstall(dstall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0; alu_out = '0; st_data = '0; npc = '0; ext = '0;
    wreg = '0; opcode = '0; MemRead = 1'b0; MemWrite = 1'b0;
    MemToReg = 1'b0; Reg_Wen = 1'b0; jal = 1'b0; halt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; dmemload = '0;
    repeat (2) tick();
    check("rst_dren", 32'(dREN), 0);
    check("rst_dstall", 32'(dstall), 0);
    nRST = 1'b1;
    tick();
    check("rst_alu_q", alu_out_q, 0);
    check("rst_halt_q", 32'(halt_q), 0);
    check("rst_dwen", 32'(dWEN), 0);
    check("rst_load", load_data, 0);

    // lw 0x100, hit after three stall cycles
    MemRead = 1'b1; MemToReg = 1'b1; Reg_Wen = 1'b1; alu_out = 32'h100;
    wreg = 5'd3; opcode = 6'h23;
    tick();
    clear_inputs(); alu_out = 32'h555;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_dren", 32'(dREN), 1);
      check("lw_dstall", 32'(dstall), 1);
      check("lw_daddr", daddr, 32'h100);
      check("lw_wreg_q", 32'(wreg_q), 3);
      tick();
    end
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    #1;
    check("lw_load", load_data, 32'hDEADBEEF);
    check("lw_hit_dstall", 32'(dstall), 0);
    tick();
    dhit = 1'b0;
    #1;
    check("lw_after_dren", 32'(dREN), 0);
    check("lw_after_daddr", daddr, 32'h555);

    // sw 0x200, hit while ihit=0 -> DONE, single write
    clear_inputs(); MemWrite = 1'b1; alu_out = 32'h200; st_data = 32'h1234;
    opcode = 6'h2b;
    tick();
    clear_inputs();
    #1;
    check("sw_dwen", 32'(dWEN), 1);
    check("sw_dstall", 32'(dstall), 1);
    check("sw_dstore", dstore, 32'h1234);
    ihit = 1'b0; dhit = 1'b1; dmemload = 32'hCAFEF00D;
    #1;
    check("sw_hit_dstall", 32'(dstall), 0);
    tick();
    dhit = 1'b0; dmemload = '0;
    #1;
    check("sw_done_dwen", 32'(dWEN), 0);
    check("sw_done_dstall", 32'(dstall), 0);
    check("sw_done_hold", 32'(MemWrite_q), 1);
    check("sw_done_load", load_data, 32'hCAFEF00D);
    tick();
    check("sw_done_dwen2", 32'(dWEN), 0);
    ihit = 1'b1;
    tick();
    check("sw_adv_memwrite_q", 32'(MemWrite_q), 0);
    check("sw_adv_dwen", 32'(dWEN), 0);

    // flush on an add -> bubble; then the same add captured normally
    Reg_Wen = 1'b1; wreg = 5'd7; alu_out = 32'h42; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_reg_wen_q", 32'(Reg_Wen_q), 0);
    check("flush_wreg_q", 32'(wreg_q), 0);
    check("flush_alu_q", alu_out_q, 0);
    check("flush_dren", 32'(dREN), 0);
    tick();
    check("add_reg_wen_q", 32'(Reg_Wen_q), 1);
    check("add_wreg_q", 32'(wreg_q), 7);

    // flush during a stall is ignored; async reset drops the request
    clear_inputs(); MemRead = 1'b1; alu_out = 32'h180;
    tick();
    clear_inputs(); flush = 1'b1;
    #1;
    check("stflush_dstall", 32'(dstall), 1);
    tick();
    check("stflush_dren", 32'(dREN), 1);
    check("stflush_memread_q", 32'(MemRead_q), 1);
    flush = 1'b0;
    nRST = 1'b0;
    #1;
    check("midrst_dren", 32'(dREN), 0);
    check("midrst_dstall", 32'(dstall), 0);
    check("midrst_daddr", daddr, 0);
    tick();
    nRST = 1'b1;

    // halt sticky; following lw becomes a bubble
    halt = 1'b1;
    tick();
    clear_inputs(); MemRead = 1'b1; alu_out = 32'h300;
    #1;
    check("halt_q_set", 32'(halt_q), 1);
    tick();
    check("halt_q_sticky", 32'(halt_q), 1);
    check("halt_bubble_memread_q", 32'(MemRead_q), 0);
    check("halt_bubble_daddr", daddr, 0);
    check("halt_dren", 32'(dREN), 0);
    tick();
    check("halt_dren2", 32'(dREN), 0);
    check("halt_q_sticky2", 32'(halt_q), 1);

    // back-to-back loads, two stall cycles each
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    clear_inputs(); MemRead = 1'b1; alu_out = 32'h400;
    tick();
    alu_out = 32'h404;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("b2b_first_daddr", daddr, 32'h400);
      tick();
    end
    dhit = 1'b1; dmemload = 32'h11111111;
    tick();
    dhit = 1'b0; clear_inputs();
    #1;
    check("b2b_second_dren", 32'(dREN), 1);
    check("b2b_second_daddr", daddr, 32'h404);
    check("b2b_second_dstall", 32'(dstall), 1);
    tick();
    tick();
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    #1;
    check("b2b_end_dren", 32'(dREN), 0);
`ifdef EXMEM_PERF_EN
    check("perf_stall", perf_stall, 4);
    check("perf_memops", perf_memops, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
